// File: rtl/debounce_if.sv
// Signal bundle between the key/button debouncer bank and the note/voice controller.
// The master modport is the debouncer side; the slave modport is the consumer side.
interface debounce_if #(
   parameter int CHANNELS = 8,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic [CHANNELS-1:0] raw_in;
   logic [CHANNELS-1:0] clean_out;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic                evt_valid;
   logic                evt_ready;
   logic [CH_W-1:0]     evt_chan;
   logic                evt_press;
   logic                evt_overflow;
   logic                overflow_clr;

   modport master (
      input  raw_in, evt_ready, overflow_clr,
      output clean_out, rise, fall, evt_valid, evt_chan, evt_press, evt_overflow
   );

   modport slave (
      output raw_in, evt_ready, overflow_clr,
      input  clean_out, rise, fall, evt_valid, evt_chan, evt_press, evt_overflow
   );
endinterface

// File: rtl/debounce_array.sv
// Multi-channel synchronise-and-filter debouncer with per-channel edge pulses and a
// round-robin arbitrated valid/ready event stream of accepted level changes.
module debounce_array #(
   parameter int CHANNELS     = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int TICK_DIV     = 12288,
   parameter int STABLE_TICKS = 12
) (
   input logic        clk,
   input logic        rst,
   debounce_if.master bus
);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

   logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
   logic [PRE_W-1:0]    r_pre;
   logic [CNT_W-1:0]    r_cnt [CHANNELS];
   logic [CHANNELS-1:0] r_clean, r_rise, r_fall;
   logic [CHANNELS-1:0] r_pend, r_pdir;
   logic                r_valid, r_press, r_ovf;
   logic [CH_W-1:0]     r_chan, r_last;

   logic [CHANNELS-1:0] w_s, w_diff, w_acc;
   logic [CHANNELS-1:0] w_pend_nxt, w_pdir_nxt;
   logic                w_tick, w_found, w_load, w_ovf_set;
   logic [CH_W-1:0]     w_idx;
   int                  w_c;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_tick = (r_pre == PRE_LAST);
   assign w_diff = w_s ^ r_clean;
   assign w_load = (!r_valid || bus.evt_ready) && w_found;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         r_pre <= '0;
      end else begin
         r_sync[0] <= bus.raw_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         if (r_pre == PRE_LAST) r_pre <= '0;
         else                   r_pre <= r_pre + PRE_W'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_acc[i] = w_diff[i] & w_tick & (r_cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
         r_clean <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else begin
         // Any cycle back in agreement throws away accumulated progress.
         for (int i = 0; i < CHANNELS; i++) begin
            if (!w_diff[i])    r_cnt[i] <= '0;
            else if (w_acc[i]) r_cnt[i] <= '0;
            else if (w_tick)   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            else               r_cnt[i] <= r_cnt[i];
         end
         r_clean <= r_clean ^ w_acc;
         r_rise  <= w_acc & w_s;
         r_fall  <= w_acc & ~w_s;
      end
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_c     = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_c = (int'(r_last) + 1 + k) % CHANNELS;
         if (!w_found && r_pend[w_c]) begin
            w_found = 1'b1;
            w_idx   = CH_W'(w_c);
         end else begin
            w_found = w_found;
         end
      end
   end

   always_comb begin
      w_pend_nxt = r_pend;
      w_pdir_nxt = r_pdir;
      w_ovf_set  = 1'b0;
      if (w_load) w_pend_nxt[w_idx] = 1'b0;
      else        w_pend_nxt = r_pend;
      // A fresh acceptance overrides a same-cycle load of that channel without overflowing.
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_acc[i]) begin
            if (r_pend[i] && !(w_load && (w_idx == CH_W'(i)))) w_ovf_set = 1'b1;
            else                                                  w_ovf_set = w_ovf_set;
            w_pend_nxt[i] = 1'b1;
            w_pdir_nxt[i] = w_s[i];
         end else begin
            w_pdir_nxt[i] = w_pdir_nxt[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend  <= '0;
         r_pdir  <= '0;
         r_valid <= 1'b0;
         r_chan  <= '0;
         r_press <= 1'b0;
         r_last  <= CH_LAST;
         r_ovf   <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_pdir <= w_pdir_nxt;
         if (w_load) begin
            r_valid <= 1'b1;
            r_chan  <= w_idx;
            r_press <= r_pdir[w_idx];
            r_last  <= w_idx;
         end else if (r_valid && bus.evt_ready) begin
            r_valid <= 1'b0;
         end
         if (w_ovf_set)             r_ovf <= 1'b1;
         else if (bus.overflow_clr) r_ovf <= 1'b0;
         else                       r_ovf <= r_ovf;
      end
   end

   assign bus.clean_out    = r_clean;
   assign bus.rise         = r_rise;
   assign bus.fall         = r_fall;
   assign bus.evt_valid    = r_valid;
   assign bus.evt_chan     = r_chan;
   assign bus.evt_press    = r_press;
   assign bus.evt_overflow = r_ovf;
endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: scenario tasks plus an event scoreboard that
// pops expected (channel, direction) pairs on every valid/ready handshake.
module tb_debounce_array;
   localparam int CH = 4;

   typedef struct packed {
      logic [1:0] chan;
      logic       press;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   ev_t  exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   hs_count = 0;

   always #5 clk = ~clk;

   debounce_if #(.CHANNELS(CH), .CH_W(2)) bus ();

   debounce_array #(
      .CHANNELS(CH), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   // Handshakes are taken at the next rising edge, so sampling on the falling edge sees them.
   always @(negedge clk) begin
      ev_t e;
      if (rst && bus.evt_valid && bus.evt_ready) begin
         hs_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL evt_unexpected: got chan=%0d press=%0d, required no event",
                     bus.evt_chan, bus.evt_press);
         end else begin
            e = exp_q.pop_front();
            if (bus.evt_chan !== e.chan || bus.evt_press !== e.press) begin
               bad++;
               $display("FAIL evt_scoreboard: got chan=%0d press=%0d, required chan=%0d press=%0d",
                        bus.evt_chan, bus.evt_press, e.chan, e.press);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) step();
      total++;
      if ({bus.clean_out, bus.rise, bus.fall, bus.evt_valid, bus.evt_chan,
           bus.evt_press, bus.evt_overflow} !== 18'd0) begin
         bad++;
         $display("FAIL reset_state: got clean=%b valid=%b ovf=%b, required all 0",
                  bus.clean_out, bus.evt_valid, bus.evt_overflow);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_press();
      int n = 0;
      bus.evt_ready = 1'b1;
      exp_q.push_back(ev_t'{chan: 2'd0, press: 1'b1});
      bus.raw_in[0] = 1'b1;
      while (n < 40 && bus.clean_out[0] !== 1'b1) begin
         step();
         n++;
      end
      // 2 synchroniser edges plus 9..12 filter cycles
      total++;
      if (n < 11 || n > 14) begin
         bad++;
         $display("FAIL press_latency: got %0d edges, required 11..14", n);
      end
      total++;
      if (bus.rise !== 4'b0001 || bus.fall !== 4'b0000) begin
         bad++;
         $display("FAIL press_rise: got rise=%b fall=%b, required rise=0001 fall=0000", bus.rise, bus.fall);
      end
      step();
      total++;
      if (bus.rise !== 4'b0000 || bus.clean_out !== 4'b0001) begin
         bad++;
         $display("FAIL press_pulse_width: got rise=%b clean=%b, required 0000/0001", bus.rise, bus.clean_out);
      end
      repeat (5) step();
      total++;
      if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL press_event: got pending=%0d valid=%b, required 0/0", exp_q.size(), bus.evt_valid);
      end
   endtask

   task automatic test_bounce();
      int viol = 0;
      for (int k = 0; k < 40; k++) begin
         if (k % 3 == 0) bus.raw_in[1] = ~bus.raw_in[1];
         step();
         if (bus.clean_out[1] !== 1'b0 || bus.rise[1] !== 1'b0 || bus.fall[1] !== 1'b0) viol++;
      end
      bus.raw_in[1] = 1'b0;
      repeat (20) begin
         step();
         if (bus.clean_out[1] !== 1'b0 || bus.rise[1] !== 1'b0 || bus.fall[1] !== 1'b0) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL bounce_filter: got %0d cycles with ch1 activity, required 0", viol);
      end
      total++;
      if (bus.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL bounce_event: got valid=%b, required 0", bus.evt_valid);
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      bus.raw_in = 4'b0000;
      repeat (2) step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      pulse_reset();
      bus.evt_ready = 1'b1;
      for (int k = 0; k < CH; k++) exp_q.push_back(ev_t'{chan: 2'(k), press: 1'b1});
      bus.raw_in = 4'b1111;
      while (n < 40 && bus.evt_valid !== 1'b1) begin
         step();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL b2b_timeout: got no valid in %0d cycles, required valid", n);
      end
      for (int k = 0; k < CH; k++) begin
         total++;
         if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 2'(k) || bus.evt_press !== 1'b1) begin
            bad++;
            $display("FAIL b2b_slot%0d: got valid=%b chan=%0d press=%b, required 1/%0d/1",
                     k, bus.evt_valid, bus.evt_chan, bus.evt_press, k);
         end
         step();
      end
      total++;
      if (bus.evt_valid !== 1'b0 || bus.clean_out !== 4'b1111) begin
         bad++;
         $display("FAIL b2b_drain: got valid=%b clean=%b, required 0/1111", bus.evt_valid, bus.clean_out);
      end
   endtask

   task automatic test_overflow();
      int n = 0;
      pulse_reset();
      bus.evt_ready = 1'b0;
      exp_q.push_back(ev_t'{chan: 2'd0, press: 1'b1});
      bus.raw_in[0] = 1'b1;
      while (n < 40 && bus.clean_out[0] !== 1'b1) begin step(); n++; end
      step();
      bus.raw_in[2] = 1'b1;
      n = 0;
      while (n < 40 && bus.clean_out[2] !== 1'b1) begin step(); n++; end
      total++;
      if (bus.evt_overflow !== 1'b0 || n >= 40) begin
         bad++;
         $display("FAIL ovf_early: got ovf=%b wait=%0d, required 0/<40", bus.evt_overflow, n);
      end
      bus.raw_in[2] = 1'b0;
      n = 0;
      while (n < 40 && bus.clean_out[2] !== 1'b0) begin step(); n++; end
      exp_q.push_back(ev_t'{chan: 2'd2, press: 1'b0});
      total++;
      if (bus.evt_overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: got ovf=%b, required 1", bus.evt_overflow);
      end
      bus.overflow_clr = 1'b1;
      step();
      bus.overflow_clr = 1'b0;
      total++;
      if (bus.evt_overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: got ovf=%b, required 0", bus.evt_overflow);
      end
   endtask

   task automatic test_hold();
      int viol = 0;
      int hs0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 2'd0 || bus.evt_press !== 1'b1) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL hold_stable: got %0d unstable cycles, required 0", viol);
      end
      hs0 = hs_count;
      bus.evt_ready = 1'b1;
      repeat (10) step();
      total++;
      if (hs_count - hs0 != 2) begin
         bad++;
         $display("FAIL hold_handshakes: got %0d, required 2", hs_count - hs0);
      end
      total++;
      if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_drain: got pending=%0d valid=%b, required 0/0", exp_q.size(), bus.evt_valid);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int viol = 0;
      bus.evt_ready = 1'b0;
      bus.raw_in[1] = 1'b1;
      while (n < 40 && bus.clean_out[1] !== 1'b1) begin step(); n++; end
      step();
      total++;
      if (bus.evt_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_setup: got valid=%b, required 1", bus.evt_valid);
      end
      bus.raw_in[3] = 1'b1;
      repeat (5) step();
      #2 rst = 1'b0;
      #1;
      total++;
      if ({bus.clean_out, bus.rise, bus.fall, bus.evt_valid, bus.evt_chan,
           bus.evt_press, bus.evt_overflow} !== 18'd0) begin
         bad++;
         $display("FAIL mid_async_reset: got clean=%b valid=%b chan=%0d, required all 0",
                  bus.clean_out, bus.evt_valid, bus.evt_chan);
      end
      bus.raw_in = 4'b0000;
      repeat (2) step();
      rst = 1'b1;
      bus.evt_ready = 1'b1;
      repeat (40) begin
         step();
         if (bus.evt_valid !== 1'b0 || bus.clean_out !== 4'b0000) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL mid_stale_event: got %0d cycles with activity, required 0", viol);
      end
   endtask

   initial begin
      bus.raw_in       = 4'b0000;
      bus.evt_ready    = 1'b0;
      bus.overflow_clr = 1'b0;
      test_reset();
      test_press();
      test_bounce();
      test_back_to_back();
      test_overflow();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
